// File: rtl/thor2022_pkg.sv
// Shared Thor2022 types: register value and bitfield opcodes.
// Consumed by the bitfield unit and its mask generator.
package thor2022_pkg;

  localparam int VALUE_W = 64;

  typedef logic [VALUE_W-1:0] Value;

  typedef enum logic [2:0] {
    BF_CLR  = 3'd0,
    BF_SET  = 3'd1,
    BF_COM  = 3'd2,
    BF_EXTU = 3'd3,
    BF_EXT  = 3'd4,
    BF_DEP  = 3'd5,
    BF_FFO  = 3'd6
  } BitfieldOp;

endpackage

// File: rtl/thor2022_bitfield_unit_if.sv
// Request/result bundle for the Thor2022 bitfield unit.
// Master issues operations, slave returns the registered result.
interface thor2022_bitfield_unit_if #(
  parameter int WID = 64,
  parameter int OW  = $clog2(WID)
);

  logic           in_valid;
  logic [2:0]     op;
  logic           use_reg;
  logic [OW-1:0]  imm_offs;
  logic [OW-1:0]  imm_wm1;
  logic [WID-1:0] a;
  logic [WID-1:0] b;
  logic [WID-1:0] c;
  logic [WID-1:0] o;
  logic           out_valid;

  modport master (
    output in_valid, op, use_reg,
    output imm_offs, imm_wm1,
    output a, b, c,
    input  o, out_valid
  );

  modport slave (
    input  in_valid, op, use_reg,
    input  imm_offs, imm_wm1,
    input  a, b, c,
    output o, out_valid
  );

endinterface

// File: rtl/thor2022_bf_mask.sv
// Field mask generator: bits offs..offs+n set, clipped at the
// top of the word with no wrap-around.
module thor2022_bf_mask #(
  parameter int WID = 64,
  parameter int OW  = $clog2(WID)
) (
  input  logic [OW-1:0]  offs,
  input  logic [OW-1:0]  n,
  output logic [WID-1:0] mask
);

  logic [OW:0]    sum;
  logic           clip;
  logic [WID-1:0] lo;
  logic [WID-1:0] hi;

  assign sum  = {1'b0, offs} + {1'b0, n};
  assign clip = sum[OW];
  assign lo   = {WID{1'b1}} << offs;
  // WID is a power of two, so ~end == WID-1-end
  assign hi   = clip ? {WID{1'b1}}
                     : ({WID{1'b1}} >> ~sum[OW-1:0]);
  assign mask = lo & hi;

endmodule

// File: rtl/thor2022_bitfield_unit.sv
// Registered bitfield unit: clr/set/com/extu/ext/dep and,
// with THOR2022_BITFIELD_FFO_EN defined, find-first-one.
module thor2022_bitfield_unit
  import thor2022_pkg::*;
#(
  parameter int WID = 64,
  localparam int OW = $clog2(WID)
) (
  input  logic clk,
  input  logic rst_n,
  thor2022_bitfield_unit_if.slave bus
);

  logic [OW-1:0]  offs;
  logic [OW-1:0]  n;
  logic [WID-1:0] mask;
  logic [WID-1:0] sh;
  logic [WID-1:0] extu;
  logic [WID-1:0] ext;
  logic [WID-1:0] dep;
  logic [WID-1:0] res;
  logic [OW:0]    sum;
  logic [OW-1:0]  s;
  logic           sign;
  logic           unused_c;
  BitfieldOp      op_e;

  assign offs = bus.use_reg ? bus.c[OW-1:0]
                            : bus.imm_offs;
  assign n    = bus.use_reg ? bus.c[2*OW-1:OW]
                            : bus.imm_wm1;
  assign unused_c = ^bus.c[WID-1:2*OW];
  assign op_e = BitfieldOp'(bus.op);

  thor2022_bf_mask #(
    .WID (WID),
    .OW  (OW)
  ) u_mask (
    .offs (offs),
    .n    (n),
    .mask (mask)
  );

  assign sh   = bus.a >> offs;
  assign extu = sh & ({WID{1'b1}} >> ~n);

  // sign bit sits at the field top, pulled down when clipped
  assign sum  = {1'b0, offs} + {1'b0, n};
  assign s    = sum[OW] ? ~offs : n;
  assign sign = sh[s];
  assign ext  = extu | (sign ? ~({WID{1'b1}} >> ~s)
                             : {WID{1'b0}});

  assign dep  = (bus.a & ~mask)
              | ((bus.b << offs) & mask);

`ifdef THOR2022_BITFIELD_FFO_EN
  logic [WID-1:0] masked;
  logic [OW-1:0]  ffo_idx;
  logic           ffo_hit;
  logic [WID-1:0] ffo_res;

  assign masked = bus.a & mask;

  always_comb begin
    ffo_hit = 1'b0;
    ffo_idx = '0;
    for (int i = WID - 1; i >= 0; i--) begin
      if (masked[i]) begin
        ffo_hit = 1'b1;
        ffo_idx = i[OW-1:0];
      end
    end
  end

  assign ffo_res = ffo_hit
    ? {{(WID-OW){1'b0}}, ffo_idx - offs}
    : {WID{1'b1}};
`endif

  always_comb begin
    res = '0;
    unique case (1'b1)
      (op_e == BF_CLR):  res = bus.a & ~mask;
      (op_e == BF_SET):  res = bus.a | mask;
      (op_e == BF_COM):  res = bus.a ^ mask;
      (op_e == BF_EXTU): res = extu;
      (op_e == BF_EXT):  res = ext;
      (op_e == BF_DEP):  res = dep;
`ifdef THOR2022_BITFIELD_FFO_EN
      (op_e == BF_FFO):  res = ffo_res;
`endif
      default:           res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid)
        bus.o <= res;
    end
  end

endmodule

// File: tb/tb_thor2022_bitfield_unit.sv
// Directed bench for thor2022_bitfield_unit: vector table
// plus reset, hold and back-to-back sequences.
module tb_thor2022_bitfield_unit;
  import thor2022_pkg::*;

  logic clk;
  logic rst_n;

  thor2022_bitfield_unit_if #(.WID(64)) bus();

  thor2022_bitfield_unit #(.WID(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef THOR2022_BITFIELD_FFO_EN
  localparam Value FFO_HIT  = 64'd4;
  localparam Value FFO_MISS = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam Value FFO_HIT  = 64'd0;
  localparam Value FFO_MISS = 64'd0;
`endif

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       use_reg;
    logic [5:0] offs;
    logic [5:0] wm1;
    Value       a;
    Value       b;
    Value       c;
    Value       exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input Value act,
                     input Value exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.op       = v.op;
    bus.use_reg  = v.use_reg;
    bus.imm_offs = v.offs;
    bus.imm_wm1  = v.wm1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.c        = v.c;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk(v.name, bus.o, v.exp);
    chk({v.name, "_vld"}, Value'(bus.out_valid), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{"extu",    3'd3, 1'b0, 6'd8,  6'd15,
                 64'h0000_0000_00AB_CD00, 64'd0, 64'd0,
                 64'h0000_0000_0000_ABCD};
    vecs[1]  = '{"ext",     3'd4, 1'b0, 6'd12, 6'd3,
                 64'h0000_0000_0000_8000, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[2]  = '{"ext_clip", 3'd4, 1'b0, 6'd62, 6'd7,
                 64'h8000_0000_0000_0000, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3]  = '{"set",     3'd1, 1'b0, 6'd4,  6'd3,
                 64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_00F0};
    vecs[4]  = '{"com",     3'd2, 1'b0, 6'd4,  6'd7,
                 64'hFF, 64'd0, 64'd0, 64'h0000_0000_0000_0F0F};
    vecs[5]  = '{"clr_all", 3'd0, 1'b0, 6'd0,  6'd63,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0};
    vecs[6]  = '{"dep_clip", 3'd5, 1'b1, 6'd0, 6'd0,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h1FC,
                 64'h0FFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{"dep",     3'd5, 1'b0, 6'd8,  6'd7,
                 64'd0, 64'h1234, 64'd0, 64'h0000_0000_0000_3400};
    vecs[8]  = '{"ffo_hit", 3'd6, 1'b0, 6'd4,  6'd15,
                 64'h100, 64'd0, 64'd0, FFO_HIT};
    vecs[9]  = '{"ffo_miss", 3'd6, 1'b0, 6'd9, 6'd3,
                 64'h100, 64'd0, 64'd0, FFO_MISS};
    vecs[10] = '{"rsvd",    3'd7, 1'b0, 6'd0,  6'd63,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0};
    vecs[11] = '{"extu_reg", 3'd3, 1'b1, 6'd0, 6'd0,
                 64'hABCD, 64'd0, 64'h1C4, 64'hBC};
    vecs[12] = '{"set_clip", 3'd1, 1'b0, 6'd60, 6'd15,
                 64'd0, 64'd0, 64'd0, 64'hF000_0000_0000_0000};
    vecs[13] = '{"ext_pos", 3'd4, 1'b0, 6'd0,  6'd7,
                 64'h7F, 64'd0, 64'd0, 64'h7F};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.use_reg  = 1'b0;
    bus.imm_offs = '0;
    bus.imm_wm1  = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;

    #12;
    chk("rst_o", bus.o, 64'd0);
    chk("rst_vld", Value'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i]);

    // idle cycle: o holds, out_valid drops
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 64'h5555;
    @(posedge clk);
    #1;
    chk("hold_o", bus.o, vecs[NV-1].exp);
    chk("hold_vld", Value'(bus.out_valid), 64'd0);

    // back-to-back in order
    run_vec(vecs[3]);
    run_vec(vecs[0]);
    run_vec(vecs[4]);

    // reset mid-stream, with a request pending
    @(negedge clk);
    drive(vecs[1]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o", bus.o, 64'd0);
    chk("arst_vld", Value'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_o", bus.o, 64'd0);
    chk("arst_hold_vld", Value'(bus.out_valid), 64'd0);

    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_idle_vld", Value'(bus.out_valid), 64'd0);
    chk("post_idle_o", bus.o, 64'd0);
    run_vec(vecs[7]);

    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("end_vld", Value'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
